// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command engine that sits behind an SPI slave deserialiser
// and fronts a single-port RAM. Each command word carries a 2-bit opcode
// and a payload. The engine keeps separate write and read pointers, which
// can optionally auto-increment. Read data leaves through a
// tx_valid/tx_ready handshake. Read commands are back-pressured while
// earlier output has not yet been consumed.
module spi_ram_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int AUTO_INC   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [DATA_WIDTH+1:0] din,
   output logic                  cmd_ready,
   input  logic                  tx_ready,
   output logic                  tx_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  addr_err
);

   typedef enum logic [1:0] {
      OP_SET_WR = 2'b00,
      OP_WRITE  = 2'b01,
      OP_SET_RD = 2'b10,
      OP_READ   = 2'b11
   } opcode_e;

   // One extra bit so that MEM_DEPTH == 2**ADDR_SIZE is representable.
   localparam logic [ADDR_SIZE:0]   DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST_C  = ADDR_SIZE'(MEM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   opcode_e               opcode_s;
   logic [DATA_WIDTH-1:0] payload_s;
   logic [ADDR_SIZE-1:0]  addr_s;
   logic                  addr_ok_s;
   logic                  cmd_ready_s;
   logic                  accept_s;
   logic                  mem_we_s;

   logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  addr_err_q, addr_err_d;

   // The pointer wraps at the last real word. This still holds when the
   // depth is not a power of two.
   function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] ptr);
      if (ptr == LAST_C) begin
         return '0;
      end else begin
         return ptr + ADDR_SIZE'(1);
      end
   endfunction

   // Split the command word and qualify it against back-pressure and the address range.
   always_comb begin
      opcode_s    = opcode_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
      payload_s   = din[DATA_WIDTH-1:0];
      addr_s      = payload_s[ADDR_SIZE-1:0];
      addr_ok_s   = ({1'b0, addr_s} < DEPTH_C);
      // Only a read can stall. Pointer loads and writes never touch the output register.
      cmd_ready_s = !(tx_valid_q && !tx_ready && (opcode_s == OP_READ));
      accept_s    = rx_valid && cmd_ready_s;
   end

   // Compute the next pointer, output and error state from the accepted command.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      dout_d     = dout_q;
      addr_err_d = 1'b0;
      mem_we_s   = 1'b0;
      // The consumer taking the data empties the output unless a new read refills it below.
      if (tx_valid_q && tx_ready) begin
         tx_valid_d = 1'b0;
      end else begin
         tx_valid_d = tx_valid_q;
      end
      if (accept_s) begin
         case (opcode_s)
            OP_SET_WR: begin
               if (addr_ok_s) begin
                  wr_ptr_d = addr_s;
               end else begin
                  addr_err_d = 1'b1;
               end
            end
            OP_WRITE: begin
               mem_we_s = 1'b1;
               if (AUTO_INC != 0) begin
                  wr_ptr_d = next_ptr(wr_ptr_q);
               end else begin
                  wr_ptr_d = wr_ptr_q;
               end
            end
            OP_SET_RD: begin
               if (addr_ok_s) begin
                  rd_ptr_d = addr_s;
               end else begin
                  addr_err_d = 1'b1;
               end
            end
            OP_READ: begin
               // The memory already holds a write from the previous edge, so read-after-write works.
               tx_valid_d = 1'b1;
               dout_d     = mem[rd_ptr_q];
               if (AUTO_INC != 0) begin
                  rd_ptr_d = next_ptr(rd_ptr_q);
               end else begin
                  rd_ptr_d = rd_ptr_q;
               end
            end
            default: begin
               wr_ptr_d = wr_ptr_q;
            end
         endcase
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Control and output registers. Reset drops any pending read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tx_valid_q <= 1'b0;
         dout_q     <= '0;
         addr_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tx_valid_q <= tx_valid_d;
         dout_q     <= dout_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Storage array. It has no reset, so its contents survive a reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem[wr_ptr_q] <= payload_s;
      end
   end

   assign cmd_ready = cmd_ready_s;
   assign tx_valid  = tx_valid_q;
   assign dout      = dout_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl. Three instances share one stimulus
// stream: the default configuration, a 200-word depth and a build without
// auto-increment. Each instance is checked only where its configuration
// matters.
module tb_spi_ram_ctrl;

   logic       clk;
   logic       rst;
   logic       rx_valid;
   logic [9:0] din;
   logic       tx_ready;

   logic       cr_def, tv_def, ae_def;
   logic [7:0] do_def;
   logic       cr_200, tv_200, ae_200;
   logic [7:0] do_200;
   logic       cr_ni, tv_ni, ae_ni;
   logic [7:0] do_ni;

   int checks;
   int errors;

   spi_ram_ctrl u_def (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .cmd_ready(cr_def),
      .tx_ready(tx_ready), .tx_valid(tv_def), .dout(do_def), .addr_err(ae_def));

   spi_ram_ctrl #(.MEM_DEPTH(200)) u_d200 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .cmd_ready(cr_200),
      .tx_ready(tx_ready), .tx_valid(tv_200), .dout(do_200), .addr_err(ae_200));

   spi_ram_ctrl #(.AUTO_INC(0)) u_ninc (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .cmd_ready(cr_ni),
      .tx_ready(tx_ready), .tx_valid(tv_ni), .dout(do_ni), .addr_err(ae_ni));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] pl);
      rx_valid = 1'b1;
      din      = {op, pl};
      tick();
      rx_valid = 1'b0;
      din      = 10'd0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      din      = 10'd0;
      tx_ready = 1'b1;
      tick();
      tick();
      chk("rst_tx_valid", {31'd0, tv_def}, 32'd0);
      chk("rst_dout", {24'd0, do_def}, 32'd0);
      chk("rst_addr_err", {31'd0, ae_def}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cr_def}, 32'd1);
      rst = 1'b0;
      tick();

      // 1: write burst at 0x10, then three back-to-back reads
      send(2'b00, 8'h10);
      send(2'b01, 8'hA1);
      send(2'b01, 8'hA2);
      send(2'b01, 8'hA3);
      send(2'b10, 8'h10);
      rx_valid = 1'b1;
      din      = {2'b11, 8'h00};
      tick();
      chk("burst_rd0", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA1});
      tick();
      chk("burst_rd1", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA2});
      tick();
      chk("burst_rd2", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA3});
      rx_valid = 1'b0;
      tick();
      chk("burst_tv_drop", {31'd0, tv_def}, 32'd0);

      // 2: back-pressure on the second of two reads
      send(2'b10, 8'h10);
      tx_ready = 1'b0;
      rx_valid = 1'b1;
      din      = {2'b11, 8'h00};
      tick();
      chk("bp_first", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA1});
      chk("bp_cmd_ready_low", {31'd0, cr_def}, 32'd0);
      tick();
      chk("bp_hold", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA1});
      chk("bp_still_low", {31'd0, cr_def}, 32'd0);
      tx_ready = 1'b1;
      #1;
      chk("bp_cmd_ready_high", {31'd0, cr_def}, 32'd1);
      tick();
      chk("bp_second", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA2});
      rx_valid = 1'b0;
      tick();
      chk("bp_tv_drop", {31'd0, tv_def}, 32'd0);

      // 3: wrap at 199 and range errors with a 200-word memory
      send(2'b00, 8'd199);
      send(2'b01, 8'h55);
      send(2'b01, 8'h66);
      send(2'b00, 8'd250);
      chk("range_err_pulse", {31'd0, ae_200}, 32'd1);
      chk("range_ok_256", {31'd0, ae_def}, 32'd0);
      tick();
      chk("range_err_clear", {31'd0, ae_200}, 32'd0);
      send(2'b01, 8'h77);
      send(2'b10, 8'd199);
      send(2'b11, 8'h00);
      chk("wrap_mem199", {24'd0, do_200}, 32'h55);
      send(2'b11, 8'h00);
      chk("wrap_mem0", {24'd0, do_200}, 32'h66);
      send(2'b11, 8'h00);
      chk("wrptr_kept_1", {24'd0, do_200}, 32'h77);
      send(2'b00, 8'd250);
      chk("dbl_err_0", {31'd0, ae_200}, 32'd1);
      send(2'b10, 8'd230);
      chk("dbl_err_1", {31'd0, ae_200}, 32'd1);
      tick();
      chk("dbl_err_end", {31'd0, ae_200}, 32'd0);

      // 4: no auto-increment, so the second write overwrites the first
      send(2'b00, 8'd5);
      send(2'b01, 8'h11);
      send(2'b01, 8'h22);
      send(2'b10, 8'd5);
      for (int i = 0; i < 3; i++) begin
         send(2'b11, 8'h00);
         chk("noinc_read", {24'd0, do_ni}, 32'h22);
      end

      // 5: reset during a stalled read, and the memory survives the reset
      tick();
      send(2'b10, 8'h10);
      tx_ready = 1'b0;
      send(2'b11, 8'h00);
      chk("pre_rst_read", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA1});
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_tv", {31'd0, tv_def}, 32'd0);
      chk("async_rst_dout", {24'd0, do_def}, 32'd0);
      tick();
      rst      = 1'b0;
      tx_ready = 1'b1;
      send(2'b10, 8'h11);
      send(2'b11, 8'h00);
      chk("mem_kept", {23'd0, tv_def, do_def}, {23'd0, 1'b1, 8'hA2});

      // 6: interleaved write, pointer load and read, plus read-after-write
      send(2'b00, 8'd7);
      send(2'b01, 8'h3C);
      send(2'b10, 8'd7);
      send(2'b11, 8'h00);
      chk("interleave", {24'd0, do_def}, 32'h3C);
      send(2'b10, 8'd8);
      send(2'b00, 8'd8);
      send(2'b01, 8'h5A);
      send(2'b11, 8'h00);
      chk("read_after_write", {24'd0, do_def}, 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
